// File: rtl/input_debouncer_n.sv
// Button/switch conditioner: 2-flop sync, per-channel debounce, press/release strobes,
// switch-change strobe and long-press reset request. Define AUTOREPEAT_EN for button auto-repeat.
module input_debouncer_n #(
    parameter int unsigned N_BTN      = 5,
    parameter int unsigned N_SW       = 8,
    parameter int unsigned DB_CYCLES  = 100000,
    parameter int unsigned LP_CYCLES  = 200000000,
    parameter int unsigned RST_BTN    = 3,
`ifdef AUTOREPEAT_EN
    parameter int unsigned REP_DELAY  = 50000000,
    parameter int unsigned REP_PERIOD = 10000000,
`endif
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_SW-1:0]  sw,
    output logic [N_BTN-1:0] btn_out,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_ok,
    output logic             sw_chg,
    output logic             rst_req
);

    localparam int unsigned       N_CH    = N_BTN + N_SW;
    localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LP_MAX  = CNT_W'(LP_CYCLES);

    logic [N_CH-1:0]  sync1, sync2;
    logic [N_CH-1:0]  lvl, lvl_nx;
    logic [CNT_W-1:0] db_cnt    [N_CH];
    logic [CNT_W-1:0] db_cnt_nx [N_CH];
    logic [CNT_W-1:0] lp_cnt, lp_cnt_nx;
    logic [N_BTN-1:0] btn_cur, btn_nx, rep_fire;
    logic [N_SW-1:0]  sw_cur, sw_nx;

    assign btn_cur = lvl[N_BTN-1:0];
    assign btn_nx  = lvl_nx[N_BTN-1:0];
    assign sw_cur  = lvl[N_CH-1:N_BTN];
    assign sw_nx   = lvl_nx[N_CH-1:N_BTN];
    assign btn_out = btn_cur;
    assign sw_ok   = sw_cur;

    // Two-flop synchroniser for all raw pins (buttons in the low bits)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw, btn};
            sync2 <= sync1;
        end
    end

    // A level is accepted after DB_CYCLES consecutive samples that disagree with it
    always_comb begin
        lvl_nx = lvl;
        for (int i = 0; i < int'(N_CH); i++) begin
            db_cnt_nx[i] = '0;
            if (sync2[i] != lvl[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    lvl_nx[i] = sync2[i];
                end else begin
                    db_cnt_nx[i] = db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl <= '0;
            for (int i = 0; i < int'(N_CH); i++) db_cnt[i] <= '0;
        end else begin
            lvl <= lvl_nx;
            for (int i = 0; i < int'(N_CH); i++) db_cnt[i] <= db_cnt_nx[i];
        end
    end

    // Long-press hold counter, saturating at LP_CYCLES
    always_comb begin
        lp_cnt_nx = '0;
        if (lvl[RST_BTN]) begin
            lp_cnt_nx = (lp_cnt == LP_MAX) ? lp_cnt : lp_cnt + CNT_W'(1);
        end
    end

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt    [N_BTN];
    logic [CNT_W-1:0] rep_cnt_nx [N_BTN];
    logic [N_BTN-1:0] rep_armed, rep_armed_nx;

    // First repeat after REP_DELAY held cycles, then every REP_PERIOD; never on the release edge
    always_comb begin
        rep_fire     = '0;
        rep_armed_nx = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            rep_cnt_nx[i] = '0;
            if (btn_cur[i]) begin
                rep_armed_nx[i] = rep_armed[i];
                if (rep_cnt[i] == (rep_armed[i] ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
                    rep_fire[i]     = btn_nx[i];
                    rep_armed_nx[i] = 1'b1;
                end else begin
                    rep_cnt_nx[i] = rep_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_armed <= '0;
            for (int i = 0; i < int'(N_BTN); i++) rep_cnt[i] <= '0;
        end else begin
            rep_armed <= rep_armed_nx;
            for (int i = 0; i < int'(N_BTN); i++) rep_cnt[i] <= rep_cnt_nx[i];
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Strobes and reset request are registered on the same edge as the level change
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_cnt      <= '0;
            btn_pulse   <= '0;
            btn_release <= '0;
            sw_chg      <= 1'b0;
            rst_req     <= 1'b0;
        end else begin
            lp_cnt      <= lp_cnt_nx;
            btn_pulse   <= (btn_nx & ~btn_cur) | rep_fire;
            btn_release <= ~btn_nx & btn_cur;
            sw_chg      <= |(sw_nx ^ sw_cur);
            rst_req     <= lvl_nx[RST_BTN] & (lp_cnt_nx == LP_MAX);
        end
    end

endmodule

// File: tb/tb_input_debouncer_n.sv
// Self-checking bench for input_debouncer_n: directed scenarios plus random stimulus
// against a window-based reference model.
module tb_input_debouncer_n;

    localparam int unsigned NB = 5;
    localparam int unsigned NS = 8;
    localparam int unsigned NC = NB + NS;
    localparam int unsigned DB = 4;
    localparam int unsigned LP = 20;
    localparam int unsigned RB = 3;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;
`ifdef AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NS-1:0] sw;
    logic [NB-1:0] btn_out, btn_pulse, btn_release;
    logic [NS-1:0] sw_ok;
    logic          sw_chg, rst_req;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [NC-1:0] m_lvl, m_s1;
    logic [NC-1:0] m_hist[$];
    logic [NB-1:0] m_pulse, m_rel;
    logic          m_chg, m_rst_req;
    int            m_held[NB];

    always #5 clk = ~clk;

    input_debouncer_n #(
        .N_BTN(NB), .N_SW(NS), .DB_CYCLES(DB), .LP_CYCLES(LP), .RST_BTN(RB),
`ifdef AUTOREPEAT_EN
        .REP_DELAY(RD), .REP_PERIOD(RP),
`endif
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw),
        .btn_out(btn_out), .btn_pulse(btn_pulse), .btn_release(btn_release),
        .sw_ok(sw_ok), .sw_chg(sw_chg), .rst_req(rst_req)
    );

    // A level flips when the last DB synchronised samples all agree on the other value.
    task automatic model_edge(input logic r, input logic [NC-1:0] raw);
        logic [NC-1:0] nl;
        int ones;
        if (r) begin
            m_s1 = '0;
            m_hist.delete();
            for (int k = 0; k < int'(DB); k++) m_hist.push_back('0);
            m_lvl = '0; m_pulse = '0; m_rel = '0; m_chg = 1'b0; m_rst_req = 1'b0;
            for (int b = 0; b < int'(NB); b++) m_held[b] = 0;
        end else begin
            nl = m_lvl;
            for (int c = 0; c < int'(NC); c++) begin
                ones = 0;
                foreach (m_hist[k]) ones += int'(m_hist[k][c]);
                if (ones == int'(DB)) nl[c] = 1'b1;
                else if (ones == 0) nl[c] = 1'b0;
            end
            for (int b = 0; b < int'(NB); b++) begin
                if (nl[b] && m_lvl[b]) m_held[b]++;
                else m_held[b] = 0;
                m_pulse[b] = (nl[b] && !m_lvl[b]) ||
                             (REP_EN && nl[b] && m_lvl[b] && m_held[b] >= int'(RD) &&
                              ((m_held[b] - int'(RD)) % int'(RP)) == 0);
                m_rel[b] = !nl[b] && m_lvl[b];
            end
            m_chg     = (nl[NC-1:NB] != m_lvl[NC-1:NB]);
            m_rst_req = nl[RB] && (m_held[RB] >= int'(LP));
            m_hist.push_back(m_s1);
            void'(m_hist.pop_front());
            m_s1  = raw;
            m_lvl = nl;
        end
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        model_edge(r, {sw, btn});
        #1;
    endtask

    function automatic logic [24:0] dut_vec();
        return {btn_out, btn_pulse, btn_release, sw_ok, sw_chg, rst_req};
    endfunction

    function automatic logic [24:0] mdl_vec();
        return {m_lvl[NB-1:0], m_pulse, m_rel, m_lvl[NC-1:NB], m_chg, m_rst_req};
    endfunction

    task automatic test_reset();
        btn = '0; sw = '0;
        step(1'b1);
        step(1'b1);
        n_vec++;
        if (dut_vec() !== 25'd0) begin
            n_err++; $display("FAIL reset_state: dut=%h expected=0", dut_vec());
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL reset_idle cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int rise = -1;
        btn[0] = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 21) btn[0] = 1'b0;
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL clean_press cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (btn_out[0] && rise < 0) begin
                rise = k;
                n_vec++;
                if (btn_pulse !== 5'b00001) begin
                    n_err++; $display("FAIL clean_press_pulse: dut=%b expected=00001", btn_pulse);
                end
            end
        end
        n_vec++;
        if (rise !== 6) begin
            n_err++; $display("FAIL clean_press_latency: dut=%0d expected=6", rise);
        end
    endtask

    task automatic test_bounce();
        int rise = -1;
        int pulses = 0;
        for (int k = 0; k < 30; k++) begin
            btn[1] = (k < 16) ? (((k / 2) % 2) == 0) : 1'b1;
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL bounce cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (btn_out[1] && rise < 0) rise = k;
            if (btn_pulse[1]) pulses++;
        end
        n_vec++;
        if (rise !== 21) begin
            n_err++; $display("FAIL bounce_latency: dut=%0d expected=21", rise);
        end
        n_vec++;
        if (pulses !== 1) begin
            n_err++; $display("FAIL bounce_pulses: dut=%0d expected=1", pulses);
        end
        btn[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL bounce_release cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_independence();
        int rise = -1;
        int chg = 0;
        int b2 = 0;
        sw[5] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            btn[2] = ~btn[2];
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL indep cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (sw_ok[5] && rise < 0) rise = k;
            if (sw_chg) chg++;
            if (btn_out[2]) b2++;
        end
        n_vec++;
        if (rise !== 6 || chg !== 1 || b2 !== 0) begin
            n_err++; $display("FAIL indep_sw5: rise=%0d chg=%0d btn2_high=%0d expected 6/1/0", rise, chg, b2);
        end
        btn[2] = 1'b0;
        sw[0] = 1'b1; sw[7] = 1'b1;
        chg = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL indep_pair cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (sw_chg) chg++;
        end
        n_vec++;
        if (chg !== 1 || sw_ok !== 8'hA1) begin
            n_err++; $display("FAIL indep_pair_chg: chg=%0d sw_ok=%h expected 1/a1", chg, sw_ok);
        end
        sw = '0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL indep_clear cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_long_press();
        int b_rise = -1, r_rise = -1, b_fall = -1, r_fall = -1, rel = -1;
        int req_hi = 0, lvl_hi = 0;
        for (int k = 1; k <= 60; k++) begin
            btn[RB] = (k <= 40);
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL long_press cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (btn_out[RB] && b_rise < 0) b_rise = k;
            if (rst_req && r_rise < 0) r_rise = k;
            if (b_rise > 0 && !btn_out[RB] && b_fall < 0) b_fall = k;
            if (r_rise > 0 && !rst_req && r_fall < 0) r_fall = k;
            if (btn_release[RB] && rel < 0) rel = k;
        end
        n_vec++;
        if (r_rise - b_rise !== 20) begin
            n_err++; $display("FAIL long_press_delay: dut=%0d expected=20", r_rise - b_rise);
        end
        n_vec++;
        if (b_fall !== 46 || r_fall !== 46 || rel !== 46) begin
            n_err++; $display("FAIL long_press_release: btn_fall=%0d req_fall=%0d release=%0d expected 46", b_fall, r_fall, rel);
        end
        for (int k = 1; k <= 30; k++) begin
            btn[RB] = (k <= 15);
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL short_press cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (rst_req) req_hi++;
            if (btn_out[RB]) lvl_hi++;
        end
        n_vec++;
        if (req_hi !== 0 || lvl_hi !== 15) begin
            n_err++; $display("FAIL short_press: rst_req_high=%0d btn_high=%0d expected 0/15", req_hi, lvl_hi);
        end
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        btn[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL reset_mid_pre cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
        end
        step(1'b1);
        n_vec++;
        if (dut_vec() !== 25'd0) begin
            n_err++; $display("FAIL reset_mid_clear: dut=%h expected=0", dut_vec());
        end
        for (int k = 1; k <= 12; k++) begin
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL reset_mid_post cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (btn_out[0] && rise < 0) rise = k;
        end
        n_vec++;
        if (rise !== 6) begin
            n_err++; $display("FAIL reset_mid_latency: dut=%0d expected=6", rise);
        end
        btn[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL reset_mid_release cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_autorepeat();
        int rise = -1;
        int obs[$];
        int exp_q[$];
        exp_q.push_back(0);
        if (REP_EN) for (int o = int'(RD); o <= 30; o += int'(RP)) exp_q.push_back(o);
        for (int k = 1; k <= 60; k++) begin
            btn[4] = (k <= 45);
            step(1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL autorepeat cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
            if (btn_out[4] && rise < 0) rise = k;
            if (rise > 0 && (k - rise) <= 30 && btn_pulse[4]) obs.push_back(k - rise);
        end
        n_vec++;
        if (obs.size() != exp_q.size()) begin
            n_err++; $display("FAIL autorepeat_count: dut=%0d expected=%0d", obs.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_vec++;
                if (obs[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL autorepeat_offset %0d: dut=%0d expected=%0d", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < int'(NB); b++)
                if ($urandom_range(0, (b == int'(RB)) ? 39 : 5) == 0) btn[b] = ~btn[b];
            for (int s = 0; s < int'(NS); s++)
                if ($urandom_range(0, 7) == 0) sw[s] = ~sw[s];
            step($urandom_range(0, 149) == 0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL random cyc %0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; btn = '0; sw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_independence();
        test_long_press();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer_n.md
Name: input_debouncer_n

Overview:
Parametrised successor to the board-level button/switch conditioner. Sits between raw FPGA pins and the CPU/SoC glue logic. Provides per-channel two-flop synchronisation, independent per-channel debounce counters, press and release pulses, and a switch-change strobe. A long-press detector on one selectable button produces a system reset request.

Parameters:
N_BTN, 5, number of push-button channels
N_SW, 8, number of slide-switch channels
DB_CYCLES, 100000, consecutive stable cycles required to accept a new level (>=1)
LP_CYCLES, 200000000, hold cycles on the reset button before rst_req asserts (>=1)
RST_BTN, 3, index of the button used for long-press reset (0..N_BTN-1)
CNT_W, 32, counter width; must hold max(DB_CYCLES, LP_CYCLES, REP_DELAY, REP_PERIOD)
REP_DELAY, 50000000, auto-repeat initial delay (used only with AUTOREPEAT_EN)
REP_PERIOD, 10000000, auto-repeat period (used only with AUTOREPEAT_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
btn  input  N_BTN  raw button pins, asynchronous
sw  input  N_SW  raw switch pins, asynchronous
btn_out  output  N_BTN  debounced button levels
btn_pulse  output  N_BTN  one-cycle press strobe per channel
btn_release  output  N_BTN  one-cycle release strobe per channel
sw_ok  output  N_SW  debounced switch levels
sw_chg  output  1  one-cycle strobe when any sw_ok bit changes
rst_req  output  1  long-press reset request, level

Behaviour:
- Reset (rst=1 at posedge): synchroniser flops, all counters, btn_out, btn_pulse, btn_release, sw_ok, sw_chg and rst_req go to 0. Reset mid-debounce discards the partial count. An input still held high after reset is re-debounced from zero.
- Sync: each bit passes through 2 flops (s1 -> s2). Only s2 is used downstream.
- Per channel (buttons and switches identical): cnt[i] is CNT_W bits.
  - If s2[i] == out[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: out[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Channels are fully independent. Activity on one channel never resets another channel's counter.
- Latency: a clean raw edge appears on out[i] exactly DB_CYCLES+2 clock edges later. A glitch lasting fewer than DB_CYCLES cycles after synchronisation produces no output change.
- btn_pulse[i] is high for exactly the one cycle in which btn_out[i] first reads 1. It is registered in the same edge that sets btn_out[i].
- btn_release[i] behaves the same way for the 1->0 transition.
- sw_chg is high for the one cycle in which any sw_ok bit differs from its previous value. Simultaneous changes on several bits give a single strobe.
- Long press: lp_cnt clears while btn_out[RST_BTN]=0. While btn_out[RST_BTN]=1, lp_cnt increments and saturates at LP_CYCLES.
  - rst_req <= 1 on the edge where lp_cnt reaches LP_CYCLES, i.e. LP_CYCLES cycles after btn_out[RST_BTN] rises.
  - rst_req stays 1 while held. It drops to 0 on the same edge that btn_out[RST_BTN] falls.
  - rst_req does not feed back into rst internally; top-level wiring decides that.
- btn_pulse on RST_BTN still fires normally on press.
- No wrap-around: debounce counters never exceed DB_CYCLES-1, and lp_cnt saturates.

Optional Feature:
AUTOREPEAT_EN
- Defined: each button channel has a repeat counter. While btn_out[i]=1, btn_pulse[i] re-asserts for one cycle after REP_DELAY cycles, then every REP_PERIOD cycles after that. The counter clears when btn_out[i]=0. Repeats never occur on btn_release, and apply to RST_BTN as well.
- Undefined: exactly one btn_pulse per press. Repeat counters and the REP_* parameters are not elaborated.

Test Plan:
All tests use DB_CYCLES=4, LP_CYCLES=20, REP_DELAY=10, REP_PERIOD=3, N_BTN=5, N_SW=8.
- Clean press: btn[0] 0->1, held 20 cycles -> btn_out[0]=1 exactly 6 edges after the change; btn_pulse[0] high 1 cycle with it; no other channel changes.
- Bounce: btn[1] toggles every 2 cycles for 16 cycles, then stays 1 -> no btn_out[1] activity during the bounce; rises 6 edges after the final edge; a single btn_pulse[1].
- Independence: btn[2] bounces continuously while sw[5] 0->1 is clean -> sw_ok[5]=1 after 6 edges; sw_chg one cycle; btn_out[2] stays 0. sw[0] and sw[7] changing together -> one sw_chg.
- Release and long press: btn[3] held 40 cycles -> rst_req rises 20 cycles after btn_out[3] rises. On release, btn_out[3] and rst_req fall on the same edge, and btn_release[3] pulses. A hold of 15 cycles -> rst_req stays 0.
- Reset mid-op: rst pulsed 1 cycle during btn[0] debounce count 3 -> all outputs 0; with btn[0] still 1, btn_out[0] rises 6 edges after rst deasserts.
- AUTOREPEAT_EN: hold btn[4] 30 cycles after btn_out[4] rises -> btn_pulse[4] at +0, +10, +13, +16, ...; without the macro, only +0.
